keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per row-scan period (legal values 4 or more).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 3, consecutive matching samples needed to accept a press or a release (legal values 2-15).
REQ-003 SHALL have port clk, input, 1 bit: clock for all logic.
REQ-004 SHALL have port RSTn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port col, input, 4 bits: keypad columns, active-low, pulled up externally, asynchronous to clk.
REQ-006 SHALL have port row, output, 4 bits: keypad row drive, active-low one-hot.
REQ-007 SHALL have port switch_in, input, 4 bits: slide switches, asynchronous to clk.
REQ-008 SHALL have port key_clear, input, 1 bit: single-cycle pulse from the bus interface; acknowledges the interrupt.
REQ-009 SHALL have port key_data, output, 4 bits: code of the last accepted key.
REQ-010 SHALL have port key_interrupt, output, 1 bit: level interrupt to IRQ[0].
REQ-011 SHALL have port key_overrun, output, 1 bit: a press was accepted while key_interrupt was still high.
REQ-012 SHALL have port switch_data, output, 4 bits: synchronized switch_in.

Function
REQ-013 SHALL pass col through a 2-flop synchronizer; these flops reset to 4'hF.
REQ-014 SHALL pass switch_in through a 2-flop synchronizer to switch_data; these flops reset to 4'h0.
REQ-015 SHALL run a period counter from 0 to SCAN_DIV-1 and wrap; the sample point is the cycle where the count equals SCAN_DIV-1.
REQ-016 SHALL evaluate the synchronized col only at sample points.
REQ-017 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-018 In SCAN, SHALL rotate row 1110, 1101, 1011, 0111, then wrap to 1110, advancing on the cycle after each sample point.
REQ-019 In SCAN, on a sample with col != 4'hF, SHALL:
- capture row_idx (0-3) and col_idx, where col_idx is the lowest-index low column;
- set the match count to 1;
- freeze row;
- go to DEBOUNCE.
REQ-020 In DEBOUNCE, on each sample:
- same col_idx: increment the match count;
- different col_idx or 4'hF: return to SCAN and resume rotation from the next row.
REQ-021 When the match count reaches DEBOUNCE_CNT, SHALL:
- load key_data = {row_idx[1:0], col_idx[1:0]};
- assert key_interrupt;
- go to PRESSED.
All three take effect on the cycle after that sample.
REQ-022 The press latency SHALL be (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles from the first detecting sample to key_interrupt high.
REQ-023 In PRESSED, SHALL keep row frozen and, on a sample with col == 4'hF, go to RELEASE with the count set to 1.
REQ-024 In RELEASE:
- each 4'hF sample increments the count;
- any other sample returns to PRESSED;
- reaching DEBOUNCE_CNT goes to SCAN, resuming rotation from the next row.
REQ-025 A held key SHALL produce exactly one acceptance; it is never auto-repeated.
REQ-026 key_interrupt SHALL stay high until a key_clear pulse, which clears it on the next cycle.
REQ-027 If key_clear and a new acceptance occur in the same cycle, key_interrupt SHALL remain 1, key_overrun SHALL be cleared, and key_data SHALL take the new code.
REQ-028 An acceptance while key_interrupt=1 and key_clear=0 SHALL set key_overrun and overwrite key_data; key_clear clears key_overrun.
REQ-029 key_clear SHALL NOT affect the FSM, row or key_data.

Reset
REQ-030 On RSTn low, asynchronously and with no clk needed, the block SHALL force:
- row=4'b1110;
- FSM=SCAN;
- period counter and match count = 0;
- key_data=4'h0;
- key_interrupt=0;
- key_overrun=0;
- switch_data=4'h0.
REQ-031 Reset in any state, including mid-DEBOUNCE or mid-RELEASE, SHALL discard the partial key; after release, scanning restarts at row 1110 with period count 0.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-032 Reset: RSTn low with clk stopped -> row=1110, key_data=0, key_interrupt=0, key_overrun=0 immediately.
REQ-033 Clean press: col=4'b1101 held while row=1011 -> key_data=4'h9 and key_interrupt=1 exactly 9 cycles after the detecting sample; row frozen at 1011 while held.
REQ-034 Bounce: col=1110 for one sample, then 1111 -> no interrupt, return to SCAN, row advances to the next value.
REQ-035 Clear while held: key_clear pulse with the key still held -> key_interrupt=0 next cycle; no re-assert until release (3 high samples) plus a fresh press.
REQ-036 Overrun: a second key (row 0, col 3) accepted before key_clear -> key_data=4'h3, key_overrun=1; key_clear -> both flags 0; same-cycle clear and press -> key_interrupt=1, key_overrun=0.
REQ-037 Switches and mid-debounce reset: switch_in=4'hA -> switch_data=4'hA within 2 cycles; RSTn pulse mid-DEBOUNCE -> no interrupt and row=1110.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, single-shot key
// acceptance, a level interrupt with overrun flag, and a synchronized copy of
// four slide switches.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic [3:0] switch_in,
  input  logic       key_clear,
  output logic [3:0] key_data,
  output logic       key_interrupt,
  output logic       key_overrun,
  output logic [3:0] switch_data
);

  localparam int               DIV_W      = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_CNT);

  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  logic [3:0]       col_s1;
  logic [3:0]       col_sync;
  logic [3:0]       sw_s1;
  logic [DIV_W-1:0] period_cnt;
  logic             sample;
  logic [1:0]       state;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [3:0]       match_cnt;
  logic [3:0]       match_next;
  logic             col_hit;
  logic [1:0]       col_low;
  logic             same_col;
  logic             accept;

  // Bring the asynchronous column lines into the clk domain; idle is all high.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      col_s1   <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_s1   <= col;
      col_sync <= col_s1;
    end
  end

  // Bring the slide switches into the clk domain.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sw_s1       <= 4'h0;
      switch_data <= 4'h0;
    end else begin
      sw_s1       <= switch_in;
      switch_data <= sw_s1;
    end
  end

  // Free-running scan period counter; its last count is the sample point.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      period_cnt <= '0;
    end else if (period_cnt == DIV_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign sample     = (period_cnt == DIV_LAST);
  assign col_hit    = (col_sync != 4'hF);
  assign match_next = match_cnt + 4'd1;
  assign same_col   = col_hit && (col_low == col_idx);
  assign accept     = sample && (state == DEBOUNCE) && same_col && (match_next == DEB_TARGET);

  // Lowest-numbered active (low) column wins when several are pressed.
  always_comb begin
    col_low = 2'd3;
    if (!col_sync[0])      col_low = 2'd0;
    else if (!col_sync[1]) col_low = 2'd1;
    else if (!col_sync[2]) col_low = 2'd2;
  end

  // Scan/debounce state machine; row_idx only moves while scanning.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      match_cnt <= 4'd0;
    end else if (sample) begin
      case (state)
        SCAN: begin
          if (col_hit) begin
            col_idx   <= col_low;
            match_cnt <= 4'd1;
            state     <= DEBOUNCE;
          end else begin
            row_idx <= row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (same_col) begin
            match_cnt <= match_next;
            if (match_next == DEB_TARGET) state <= PRESSED;
          end else begin
            match_cnt <= 4'd0;
            state     <= SCAN;
            row_idx   <= row_idx + 2'd1;
          end
        end
        PRESSED: begin
          if (!col_hit) begin
            match_cnt <= 4'd1;
            state     <= RELEASE;
          end
        end
        default: begin
          if (col_hit) begin
            state <= PRESSED;
          end else if (match_next == DEB_TARGET) begin
            match_cnt <= 4'd0;
            state     <= SCAN;
            row_idx   <= row_idx + 2'd1;
          end else begin
            match_cnt <= match_next;
          end
        end
      endcase
    end
  end

  // Row drive is the active-low decode of the current row index.
  always_comb begin
    row = ~(4'b0001 << row_idx);
  end

  // Latch accepted keys and manage the interrupt/overrun flags; a new key wins over a clear.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      key_data      <= 4'h0;
      key_interrupt <= 1'b0;
      key_overrun   <= 1'b0;
    end else if (accept) begin
      key_data      <= {row_idx, col_idx};
      key_overrun   <= key_interrupt & ~key_clear;
      key_interrupt <= 1'b1;
    end else if (key_clear) begin
      key_interrupt <= 1'b0;
      key_overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized and directed stimulus against a sample-level
// behavioural model of the keypad scanner, checked every clock cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk;
  logic       RSTn;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] switch_in;
  logic       key_clear;
  logic [3:0] key_data;
  logic       key_interrupt;
  logic       key_overrun;
  logic [3:0] switch_data;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .RSTn(RSTn), .col(col), .row(row), .switch_in(switch_in),
    .key_clear(key_clear), .key_data(key_data), .key_interrupt(key_interrupt),
    .key_overrun(key_overrun), .switch_data(switch_data)
  );

  bit clkEn = 1'b1;
  int errors = 0;
  int checks = 0;

  // Keypad stimulus: 0 = nothing pressed, 1 = matrix key, 2 = raw column value
  int         keyMode = 0;
  logic [1:0] keyRow  = 2'd0;
  logic [1:0] keyCol  = 2'd0;
  logic [3:0] rawCol  = 4'hF;

  // Behavioural model: positions within the scan period, scanned row, activity phase
  int         mTick;
  int         mRow;
  int         mPhase;   // 0 idle scanning, 1 confirming press, 2 held, 3 confirming release
  int         mStreak;
  int         mCand;
  logic [3:0] mSeen1, mSeen2;
  logic [3:0] mSwPrev, mSw, mData;
  logic       mIrq, mOvr;

  // Gated clock so reset can be tested with no edges
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clkEn) clk = ~clk;
    end
  end

  // Watchdog against any unbounded stall
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lowIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mTick = 0; mRow = 0; mPhase = 0; mStreak = 0; mCand = 0;
    mSeen1 = 4'hF; mSeen2 = 4'hF;
    mSwPrev = 4'h0; mSw = 4'h0; mData = 4'h0;
    mIrq = 1'b0; mOvr = 1'b0;
  endtask

  // One clock of the model: the column seen two edges ago is judged at the sample point
  task automatic modelStep();
    logic [3:0] seen;
    int  low;
    bit  isSample;
    bit  accepted;
    seen     = mSeen2;
    low      = lowIdx(seen);
    isSample = (mTick == SCAN_DIV - 1);
    mTick    = (mTick + 1) % SCAN_DIV;
    accepted = 0;
    if (isSample) begin
      if (mPhase == 0) begin
        if (low >= 0) begin mCand = low; mStreak = 1; mPhase = 1; end
        else mRow = (mRow + 1) % 4;
      end else if (mPhase == 1) begin
        if (low == mCand) begin
          mStreak++;
          if (mStreak == DEBOUNCE_CNT) begin accepted = 1; mPhase = 2; end
        end else begin
          mPhase = 0; mRow = (mRow + 1) % 4;
        end
      end else if (mPhase == 2) begin
        if (low < 0) begin mPhase = 3; mStreak = 1; end
      end else begin
        if (low >= 0) mPhase = 2;
        else begin
          mStreak++;
          if (mStreak == DEBOUNCE_CNT) begin mPhase = 0; mRow = (mRow + 1) % 4; end
        end
      end
    end
    if (accepted) begin
      mData = 4'(mRow * 4 + mCand);
      mOvr  = mIrq && !key_clear;
      mIrq  = 1'b1;
    end else if (key_clear) begin
      mIrq = 1'b0;
      mOvr = 1'b0;
    end
    mSeen2  = mSeen1;
    mSeen1  = col;
    mSw     = mSwPrev;
    mSwPrev = switch_in;
  endtask

  function automatic bit modelWillAccept();
    return (mPhase == 1) && (mTick == SCAN_DIV - 1) &&
           (mStreak == DEBOUNCE_CNT - 1) && (lowIdx(mSeen2) == mCand);
  endfunction

  task automatic checkLit(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] expRow;
    expRow = ~(4'b0001 << mRow);
    checkLit("row", row, expRow);
    checkLit("key_data", key_data, mData);
    checkLit("key_interrupt", {3'b000, key_interrupt}, {3'b000, mIrq});
    checkLit("key_overrun", {3'b000, key_overrun}, {3'b000, mOvr});
    checkLit("switch_data", switch_data, mSw);
  endtask

  // Drive the column lines as a physical keypad would for the current row drive
  task automatic applyStimulus();
    logic [3:0] rowSel, colSel;
    rowSel = ~(4'b0001 << keyRow);
    colSel = ~(4'b0001 << keyCol);
    if (keyMode == 1)      col = (row == rowSel) ? colSel : 4'hF;
    else if (keyMode == 2) col = rawCol;
    else                   col = 4'hF;
  endtask

  task automatic tick();
    applyStimulus();
    @(posedge clk);
    if (!RSTn) modelReset();
    else       modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pressKey(input logic [1:0] r, input logic [1:0] c);
    keyMode = 1; keyRow = r; keyCol = c;
  endtask

  task automatic waitKey(input string name, input logic [3:0] code);
    bit seen;
    seen = 0;
    for (int i = 0; i < 150 && !seen; i++) begin
      tick();
      if (key_interrupt === 1'b1 && key_data === code) seen = 1;
    end
    checkLit(name, {3'b000, seen}, 4'h1);
  endtask

  task automatic pulseClear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; col = 4'hF; switch_in = 4'h0; key_clear = 1'b0;
    modelReset();
    ticks(2);

    // Clean press of row 2 / column 1 held from reset release
    RSTn = 1'b1;
    pressKey(2'd2, 2'd1);
    ticks(19);
    checkLit("press_not_yet", {3'b000, key_interrupt}, 4'h0);
    tick();
    checkLit("press_irq", {3'b000, key_interrupt}, 4'h1);
    checkLit("press_code", key_data, 4'h9);
    checkLit("press_row", row, 4'b1011);
    ticks(20);
    checkLit("held_row_frozen", row, 4'b1011);

    // Clear while held, no auto-repeat
    pulseClear();
    checkLit("clear_irq", {3'b000, key_interrupt}, 4'h0);
    ticks(40);
    checkLit("held_no_repeat", {3'b000, key_interrupt}, 4'h0);
    keyMode = 0;
    ticks(30);
    checkLit("release_no_irq", {3'b000, key_interrupt}, 4'h0);
    pressKey(2'd2, 2'd1);
    waitKey("repress_irq", 4'h9);

    // Overrun: second key before any clear
    keyMode = 0;
    ticks(30);
    pressKey(2'd0, 2'd3);
    waitKey("second_key", 4'h3);
    checkLit("overrun_set", {3'b000, key_overrun}, 4'h1);
    pulseClear();
    checkLit("clear_irq2", {3'b000, key_interrupt}, 4'h0);
    checkLit("clear_ovr", {3'b000, key_overrun}, 4'h0);
    keyMode = 0;
    ticks(30);
    pressKey(2'd3, 2'd0);
    waitKey("third_key", 4'hC);
    keyMode = 0;
    ticks(30);

    // Clear in the same cycle as a new acceptance
    pressKey(2'd1, 2'd2);
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        if (modelWillAccept()) found = 1;
        else tick();
      end
      checkLit("accept_window", {3'b000, found}, 4'h1);
    end
    pulseClear();
    checkLit("same_cycle_irq", {3'b000, key_interrupt}, 4'h1);
    checkLit("same_cycle_ovr", {3'b000, key_overrun}, 4'h0);
    checkLit("same_cycle_code", key_data, 4'h6);

    // Asynchronous reset with the clock stopped
    keyMode = 0;
    clkEn = 1'b0;
    #3;
    RSTn = 1'b0;
    #7;
    modelReset();
    checkLit("async_row", row, 4'b1110);
    checkLit("async_data", key_data, 4'h0);
    checkLit("async_irq", {3'b000, key_interrupt}, 4'h0);
    checkLit("async_ovr", {3'b000, key_overrun}, 4'h0);
    clkEn = 1'b1;
    ticks(2);

    // Bounce: one low sample then idle
    RSTn = 1'b1;
    keyMode = 2; rawCol = 4'b1110;
    ticks(4);
    checkLit("bounce_frozen", row, 4'b1110);
    keyMode = 0;
    ticks(4);
    checkLit("bounce_next_row", row, 4'b1101);
    checkLit("bounce_no_irq", {3'b000, key_interrupt}, 4'h0);

    // Switch synchronizer latency
    switch_in = 4'hA;
    ticks(2);
    checkLit("switch_sync", switch_data, 4'hA);

    // Reset during debounce discards the partial key
    RSTn = 1'b0;
    tick();
    RSTn = 1'b1;
    pressKey(2'd1, 2'd0);
    ticks(10);
    checkLit("debounce_row", row, 4'b1101);
    RSTn = 1'b0;
    #1;
    checkLit("mid_reset_row", row, 4'b1110);
    keyMode = 0;
    tick();
    RSTn = 1'b1;
    ticks(30);
    checkLit("mid_reset_no_irq", {3'b000, key_interrupt}, 4'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        int pick;
        pick = $urandom_range(0, 9);
        if (pick < 4) keyMode = 0;
        else if (pick < 8) pressKey(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        else begin keyMode = 2; rawCol = 4'($urandom_range(0, 15)); end
      end
      if ($urandom_range(0, 15) == 0) switch_in = 4'($urandom_range(0, 15));
      key_clear = ($urandom_range(0, 7) == 0);
      RSTn = ($urandom_range(0, 599) != 0);
      tick();
    end
    key_clear = 1'b0;
    RSTn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
